// File: rtl/riscv32b_gpio_pkg.sv
// Shared constants for the riscv32b GPIO peripheral: register word offsets,
// window geometry and small mask helpers used by the register file.
// Latency: n/a (constants only). Backpressure: n/a.
package riscv32b_gpio_pkg;

  // The peripheral occupies one 32-byte window: eight 32-bit registers.
  localparam int WIN_BYTES = 32;
  localparam int WIN_LSB   = $clog2(WIN_BYTES);

  // Register offsets as word indices (byte address bits [4:2]).
  localparam logic [2:0] OFF_OUT  = 3'd0;
  localparam logic [2:0] OFF_DIR  = 3'd1;
  localparam logic [2:0] OFF_IN   = 3'd2;
  localparam logic [2:0] OFF_IEN  = 3'd3;
  localparam logic [2:0] OFF_EDGE = 3'd4;
  localparam logic [2:0] OFF_STAT = 3'd5;
  localparam logic [2:0] OFF_SET  = 3'd6;
  localparam logic [2:0] OFF_CLR  = 3'd7;

  // Ones in the bit positions that correspond to real pins. Written as a
  // loop so that a full 32-pin build needs no zero-width replication.
  function automatic logic [31:0] pin_mask(input int w);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Expand the four byte-lane strobes into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] lanes);
    return {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
  endfunction

endpackage

// File: rtl/riscv32b_gpio_if.sv
// Data-bus bundle between the riscv32b core side and a memory-mapped peer.
// Latency: n/a (wiring only). Backpressure: none; the bus never stalls.
// Ports: addr/mem_rd/mem_wr/data_wr0..3 from master, data_rd/sel from slave.
interface riscv32b_gpio_if;
  logic [31:0] addr;      // byte address
  logic        mem_rd;    // read strobe
  logic [3:0]  mem_wr;    // byte-lane write strobes
  logic [7:0]  data_wr0;  // write data bits 7:0
  logic [7:0]  data_wr1;  // write data bits 15:8
  logic [7:0]  data_wr2;  // write data bits 23:16
  logic [7:0]  data_wr3;  // write data bits 31:24
  logic [31:0] data_rd;   // registered read data
  logic        sel;       // address falls in the slave's window

  modport master (
    output addr, mem_rd, mem_wr, data_wr0, data_wr1, data_wr2, data_wr3,
    input  data_rd, sel
  );

  modport slave (
    input  addr, mem_rd, mem_wr, data_wr0, data_wr1, data_wr2, data_wr3,
    output data_rd, sel
  );
endinterface

// File: rtl/riscv32b_sync.sv
// Multi-flop synchroniser for a bus of independent asynchronous bits.
// Latency: STAGES clk cycles. Backpressure: none.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronised out).
module riscv32b_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/riscv32b_gpio.sv
// Memory-mapped GPIO: direction, atomic set/clear, synchronised inputs and
// per-pin edge interrupts with W1C status. Read data 1 cycle after mem_rd;
// writes land on the strobe edge. Backpressure: none, every access completes.
// Ports: clk, rst (sync, active-high), bus (slave modport), gpio_i (async),
// gpio_o / gpio_oe (pin drive), irq (registered level).
module riscv32b_gpio
  import riscv32b_gpio_pkg::*;
#(
  parameter int          GPIO_W      = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  riscv32b_gpio_if.slave    bus,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] gpio_o,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq
);

  localparam logic [31:0] PMASK   = pin_mask(GPIO_W);
  localparam int          BLANK_W = $clog2(SYNC_STAGES + 2);
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(SYNC_STAGES + 1);

  // ---------------------------------------------------------------- decode
  logic        sel;
  logic [2:0]  offset;
  logic [31:0] wdata;
  logic [31:0] wmask;
  logic        wr_en;
  logic        unused_addr_lsbs;

  assign sel    = (bus.addr[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
  assign offset = bus.addr[WIN_LSB-1:2];
  assign wdata  = {bus.data_wr3, bus.data_wr2, bus.data_wr1, bus.data_wr0};
  // Lanes that are strobed and bits that map to real pins.
  assign wmask  = lane_mask(bus.mem_wr) & PMASK;
  assign wr_en  = sel & (|bus.mem_wr);
  assign bus.sel = sel;
  // Byte offset within a word carries no meaning for word registers.
  assign unused_addr_lsbs = ^bus.addr[1:0];

  // -------------------------------------------------------------- registers
  logic [31:0] out_q,      out_d;
  logic [31:0] dir_q,      dir_d;
  logic [31:0] ien_q,      ien_d;
  logic [31:0] edge_sel_q, edge_sel_d;
  logic [31:0] stat_q,     stat_d;
  logic [31:0] data_rd_q,  data_rd_d;
  logic        irq_q,      irq_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic [GPIO_W-1:0]  s_dly_q, s_dly_d;

  // ------------------------------------------------------------ input path
  logic [GPIO_W-1:0] s;
  logic [GPIO_W-1:0] rise;
  logic [GPIO_W-1:0] fall;
  logic [GPIO_W-1:0] ev;
  logic [31:0]       w1c_mask;

  riscv32b_sync #(
    .WIDTH  (GPIO_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (gpio_i),
    .q   (s)
  );

  assign s_dly_d = s;
  assign rise    = s & ~s_dly_q;
  assign fall    = ~s & s_dly_q;

  // After reset the sync chain fills with whatever the pins hold; a pin
  // that was high through reset would otherwise look like a rising edge.
  // Events are suppressed until the chain and s_dly have both settled.
  always_comb begin
    blank_d = blank_q;
    if (blank_q != '0) blank_d = blank_q - 1'b1;
  end

  always_comb begin
    ev = (edge_sel_q[GPIO_W-1:0] & fall) | (~edge_sel_q[GPIO_W-1:0] & rise);
    if (blank_q != '0) ev = '0;
  end

  // ------------------------------------------------------ register writes
  always_comb begin
    out_d      = out_q;
    dir_d      = dir_q;
    ien_d      = ien_q;
    edge_sel_d = edge_sel_q;
    w1c_mask   = '0;
    if (wr_en) begin
      case (offset)
        OFF_OUT:  out_d      = (out_q & ~wmask) | (wdata & wmask);
        OFF_DIR:  dir_d      = (dir_q & ~wmask) | (wdata & wmask);
        OFF_IEN:  ien_d      = (ien_q & ~wmask) | (wdata & wmask);
        OFF_EDGE: edge_sel_d = (edge_sel_q & ~wmask) | (wdata & wmask);
        OFF_STAT: w1c_mask   = wdata & wmask;
        OFF_SET:  out_d      = out_q | (wdata & wmask);
        OFF_CLR:  out_d      = out_q & ~(wdata & wmask);
        default:  ;
      endcase
    end
  end

  // A fresh event beats a W1C of the same bit in the same cycle.
  assign stat_d = (stat_q & ~w1c_mask) | 32'(ev);
  assign irq_d  = |(stat_q & ien_q);

  // -------------------------------------------------------------- read mux
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    case (offset)
      OFF_OUT:  rdata = out_q;
      OFF_DIR:  rdata = dir_q;
      OFF_IN:   rdata = 32'(s);
      OFF_IEN:  rdata = ien_q;
      OFF_EDGE: rdata = edge_sel_q;
      OFF_STAT: rdata = stat_q;
      default:  rdata = '0;
    endcase
  end

  always_comb begin
    data_rd_d = data_rd_q;
    if (bus.mem_rd && sel) data_rd_d = rdata;
  end

  // ------------------------------------------------------------- state regs
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      dir_q      <= '0;
      ien_q      <= '0;
      edge_sel_q <= '0;
      stat_q     <= '0;
      data_rd_q  <= '0;
      irq_q      <= 1'b0;
      s_dly_q    <= '0;
      blank_q    <= BLANK_LOAD;
    end else begin
      out_q      <= out_d;
      dir_q      <= dir_d;
      ien_q      <= ien_d;
      edge_sel_q <= edge_sel_d;
      stat_q     <= stat_d;
      data_rd_q  <= data_rd_d;
      irq_q      <= irq_d;
      s_dly_q    <= s_dly_d;
      blank_q    <= blank_d;
    end
  end

  assign gpio_o      = out_q[GPIO_W-1:0];
  assign gpio_oe     = dir_q[GPIO_W-1:0];
  assign irq         = irq_q;
  assign bus.data_rd = data_rd_q;

endmodule

// File: tb/tb_riscv32b_gpio.sv
`timescale 1ns/1ps
module tb_riscv32b_gpio;

  localparam int          W    = 8;
  localparam int          S    = 2;
  localparam logic [31:0] BASE = 32'h0000_0400;

  localparam logic [31:0] A_OUT  = BASE + 32'h00;
  localparam logic [31:0] A_DIR  = BASE + 32'h04;
  localparam logic [31:0] A_IN   = BASE + 32'h08;
  localparam logic [31:0] A_IEN  = BASE + 32'h0C;
  localparam logic [31:0] A_EDGE = BASE + 32'h10;
  localparam logic [31:0] A_STAT = BASE + 32'h14;
  localparam logic [31:0] A_SET  = BASE + 32'h18;
  localparam logic [31:0] A_CLR  = BASE + 32'h1C;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] gpio_i = '0;
  logic [W-1:0] gpio_o;
  logic [W-1:0] gpio_oe;
  logic         irq;

  int n_cmp = 0;
  int n_bad = 0;

  riscv32b_gpio_if bus();

  riscv32b_gpio #(
    .GPIO_W      (W),
    .BASE_ADDR   (BASE),
    .SYNC_STAGES (S)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [3:0] lanes, input logic [31:0] d);
    bus.addr = a;
    bus.mem_wr = lanes;
    {bus.data_wr3, bus.data_wr2, bus.data_wr1, bus.data_wr0} = d;
    tick();
    bus.mem_wr = 4'b0000;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    bus.mem_rd = 1'b1;
    tick();
    bus.mem_rd = 1'b0;
    d = bus.data_rd;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    gpio_i = '0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    n_cmp++; if (gpio_o !== 8'h00) begin n_bad++; $display("FAIL reset_gpio_o: got %h expected 00", gpio_o); end
    n_cmp++; if (gpio_oe !== 8'h00) begin n_bad++; $display("FAIL reset_gpio_oe: got %h expected 00", gpio_oe); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b expected 0", irq); end
    for (int k = 0; k < 8; k++) begin
      bus_read(BASE + 32'(4 * k), rd);
      n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_read off=%0h: got %h expected 0", 4 * k, rd); end
    end
    // pins held high through a reset must not look like rising edges
    gpio_i = 8'hFF;
    repeat (3) tick();
    pulse_reset();
    repeat (8) tick();
    bus_read(A_STAT, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_blank_stat: got %h expected 0", rd); end
    bus_read(A_IN, rd);
    n_cmp++; if (rd !== 32'hFF) begin n_bad++; $display("FAIL reset_in_read: got %h expected ff", rd); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_blank_irq: got %b expected 0", irq); end
    gpio_i = '0;
    repeat (6) tick();
  endtask

  task automatic test_out();
    logic [31:0] rd;
    bus_write(A_OUT, 4'b0001, 32'h0000_00A5);
    n_cmp++; if (gpio_o !== 8'hA5) begin n_bad++; $display("FAIL out_write: got %h expected a5", gpio_o); end
    bus_write(A_SET, 4'b1111, 32'h0000_000A);
    n_cmp++; if (gpio_o !== 8'hAF) begin n_bad++; $display("FAIL out_set: got %h expected af", gpio_o); end
    bus_write(A_CLR, 4'b1111, 32'h0000_0081);
    n_cmp++; if (gpio_o !== 8'h2E) begin n_bad++; $display("FAIL out_clr: got %h expected 2e", gpio_o); end
    bus_write(A_OUT, 4'b0010, 32'h0000_FF00);
    n_cmp++; if (gpio_o !== 8'h2E) begin n_bad++; $display("FAIL out_lane1: got %h expected 2e", gpio_o); end
    bus_read(A_OUT, rd);
    n_cmp++; if (rd !== 32'h2E) begin n_bad++; $display("FAIL out_readback: got %h expected 2e", rd); end
    // lane 0 strobe only: upper data bytes must be ignored
    bus_write(A_DIR, 4'b0001, 32'hFFFF_FF3C);
    n_cmp++; if (gpio_oe !== 8'h3C) begin n_bad++; $display("FAIL dir_write: got %h expected 3c", gpio_oe); end
    bus_read(A_DIR, rd);
    n_cmp++; if (rd !== 32'h3C) begin n_bad++; $display("FAIL dir_readback: got %h expected 3c", rd); end
    bus_read(A_CLR, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL clr_reads_zero: got %h expected 0", rd); end
  endtask

  task automatic test_irq();
    logic [31:0] rd;
    bus_write(A_IEN, 4'b1111, 32'h01);
    bus_write(A_EDGE, 4'b1111, 32'h00);
    // data_rd after edge k shows STAT as it was after edge k-1
    bus.addr = A_STAT;
    bus.mem_rd = 1'b1;
    gpio_i[0] = 1'b1;
    for (int k = 1; k <= S + 2; k++) begin
      tick();
      if (k == S + 1) begin
        n_cmp++; if (bus.data_rd !== 32'h0) begin n_bad++; $display("FAIL irq_stat_early: got %h expected 0", bus.data_rd); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_early: got %b expected 0", irq); end
      end
      if (k == S + 2) begin
        n_cmp++; if (bus.data_rd !== 32'h1) begin n_bad++; $display("FAIL irq_stat_set: got %h expected 1", bus.data_rd); end
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_assert: got %b expected 1", irq); end
      end
    end
    bus.mem_rd = 1'b0;
    bus_write(A_STAT, 4'b1111, 32'h01);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_hold_on_w1c: got %b expected 1", irq); end
    tick();
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_clear: got %b expected 0", irq); end
    bus_read(A_STAT, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL irq_stat_cleared: got %h expected 0", rd); end
  endtask

  task automatic test_edge_collision();
    logic [31:0] rd;
    bus_write(A_EDGE, 4'b1111, 32'h08);
    gpio_i[3] = 1'b1;
    repeat (6) tick();
    bus_read(A_STAT, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL fall_mode_rise: got %h expected 0", rd); end
    gpio_i[3] = 1'b0;
    repeat (6) tick();
    bus_read(A_STAT, rd);
    n_cmp++; if (rd !== 32'h08) begin n_bad++; $display("FAIL fall_mode_fall: got %h expected 08", rd); end
    gpio_i[3] = 1'b1;
    repeat (6) tick();
    bus_write(A_STAT, 4'b1111, 32'h08);
    bus_read(A_STAT, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL w1c_bit3: got %h expected 0", rd); end
    // falling edge reaches STAT on the same edge as the W1C of bit 3
    gpio_i[3] = 1'b0;
    repeat (S) tick();
    bus_write(A_STAT, 4'b1111, 32'h08);
    bus_read(A_STAT, rd);
    n_cmp++; if (rd !== 32'h08) begin n_bad++; $display("FAIL event_beats_w1c: got %h expected 08", rd); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL masked_irq: got %b expected 0", irq); end
    bus_write(A_STAT, 4'b1111, 32'h08);
    bus_read(A_STAT, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL w1c_after_collision: got %h expected 0", rd); end
  endtask

  task automatic test_decode();
    logic [31:0] rd;
    bus.addr = BASE + 32'h20;
    #1;
    n_cmp++; if (bus.sel !== 1'b0) begin n_bad++; $display("FAIL sel_above: got %b expected 0", bus.sel); end
    bus.addr = BASE - 32'h4;
    #1;
    n_cmp++; if (bus.sel !== 1'b0) begin n_bad++; $display("FAIL sel_below: got %b expected 0", bus.sel); end
    bus.addr = A_CLR;
    #1;
    n_cmp++; if (bus.sel !== 1'b1) begin n_bad++; $display("FAIL sel_inside: got %b expected 1", bus.sel); end
    bus_write(BASE + 32'h20, 4'b1111, 32'hFFFF_FFFF);
    bus_write(BASE - 32'h4, 4'b1111, 32'hFFFF_FFFF);
    bus_write(BASE + 32'h24, 4'b1111, 32'h0000_0000);
    n_cmp++; if (gpio_o !== 8'h2E) begin n_bad++; $display("FAIL decode_out_kept: got %h expected 2e", gpio_o); end
    n_cmp++; if (gpio_oe !== 8'h3C) begin n_bad++; $display("FAIL decode_dir_kept: got %h expected 3c", gpio_oe); end
    bus_read(A_OUT, rd);
    bus_read(BASE + 32'h20, rd);
    n_cmp++; if (rd !== 32'h2E) begin n_bad++; $display("FAIL decode_rd_hold: got %h expected 2e", rd); end
    bus_read(A_SET, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL set_reads_zero: got %h expected 0", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    bus_write(A_IEN, 4'b1111, 32'hFF);
    bus_read(A_OUT, rd);
    bus.addr = A_OUT;
    bus.mem_wr = 4'b1111;
    {bus.data_wr3, bus.data_wr2, bus.data_wr1, bus.data_wr0} = 32'h0000_00FF;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.mem_wr = 4'b0000;
    n_cmp++; if (gpio_o !== 8'h00) begin n_bad++; $display("FAIL midrst_out: got %h expected 00", gpio_o); end
    n_cmp++; if (gpio_oe !== 8'h00) begin n_bad++; $display("FAIL midrst_dir: got %h expected 00", gpio_oe); end
    n_cmp++; if (bus.data_rd !== 32'h0) begin n_bad++; $display("FAIL midrst_data_rd: got %h expected 0", bus.data_rd); end
    repeat (6) tick();
    bus_read(A_IEN, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL midrst_ien: got %h expected 0", rd); end
    bus_read(A_EDGE, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL midrst_edge: got %h expected 0", rd); end
    bus_read(A_STAT, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL midrst_stat: got %h expected 0", rd); end
  endtask

  task automatic test_random();
    localparam logic [W-1:0] M_EDGE = 8'h5A;
    localparam logic [W-1:0] M_IEN  = 8'hC3;
    logic [W-1:0] m_chain [S];
    logic [W-1:0] m_sd, m_s, m_stat, rise, fall, ev, pin, wm;
    logic [31:0]  exp_rd;
    logic         exp_irq, dow;
    gpio_i = '0;
    pulse_reset();
    bus_write(A_EDGE, 4'b1111, 32'(M_EDGE));
    bus_write(A_IEN, 4'b1111, 32'(M_IEN));
    repeat (8) tick();
    for (int j = 0; j < S; j++) m_chain[j] = '0;
    m_sd = '0;
    m_stat = '0;
    for (int i = 0; i < 10000; i++) begin
      pin = W'($urandom);
      wm  = W'($urandom);
      dow = (i % 37 == 5);
      gpio_i = pin;
      bus.addr = A_STAT;
      bus.mem_rd = 1'b1;
      bus.mem_wr = dow ? 4'b1111 : 4'b0000;
      {bus.data_wr3, bus.data_wr2, bus.data_wr1} = 24'($urandom);
      bus.data_wr0 = wm;
      m_s = m_chain[S-1];
      rise = m_s & ~m_sd;
      fall = ~m_s & m_sd;
      ev = (M_EDGE & fall) | (~M_EDGE & rise);
      exp_rd = 32'(m_stat);
      exp_irq = |(m_stat & M_IEN);
      m_stat = (m_stat & ~(dow ? wm : 8'h00)) | ev;
      m_sd = m_s;
      for (int j = S - 1; j > 0; j--) m_chain[j] = m_chain[j-1];
      m_chain[0] = pin;
      tick();
      n_cmp++; if (bus.data_rd !== exp_rd) begin n_bad++; $display("FAIL rand_stat cyc=%0d: got %h expected %h", i, bus.data_rd, exp_rd); end
      n_cmp++; if (irq !== exp_irq) begin n_bad++; $display("FAIL rand_irq cyc=%0d: got %b expected %b", i, irq, exp_irq); end
    end
    bus.mem_rd = 1'b0;
    bus.mem_wr = 4'b0000;
  endtask

  initial begin
    bus.addr = '0;
    bus.mem_rd = 1'b0;
    bus.mem_wr = 4'b0000;
    bus.data_wr0 = '0;
    bus.data_wr1 = '0;
    bus.data_wr2 = '0;
    bus.data_wr3 = '0;
    test_reset();
    test_out();
    test_irq();
    test_edge_collision();
    test_decode();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
